pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 17 +
 rtl/pipe_adder_add_slice.sv | 16 +
 rtl/pipe_adder.sv | 101 ++++++++++
 tb/tb_pipe_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and per-stage register layout for the segmented pipelined adder.
// Fields are sized to MaxWidth so any legal Width fits; pipe_adder uses only the low Width bits.
package pipe_adder_pkg;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultStages = 4;
    localparam int unsigned MaxWidth      = 64;

    typedef struct packed {
        logic                valid;
        logic                carry;
        logic [MaxWidth-1:0] a;
        logic [MaxWidth-1:0] b;
        logic [MaxWidth-1:0] psum;
    } stage_t;

endpackage

// File: rtl/pipe_adder_add_slice.sv
// Combinational Chunk-bit adder with carry in and carry out; one instance per pipeline stage.
module add_slice #(
    parameter int unsigned Chunk = 4
) (
    input  logic [Chunk-1:0] a,
    input  logic [Chunk-1:0] b,
    input  logic             c_in,
    output logic [Chunk-1:0] sum,
    output logic             c_out
);

    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {{Chunk{1'b0}}, c_in};
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined unsigned adder: Stages chunks, LSB first, carry registered between stages.
// Define PIPE_ADDER_SAT_EN to saturate sum to all ones when the full-width add carries out.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned Width  = DefaultWidth,
    parameter int unsigned Stages = DefaultStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned Chunk = Width / Stages;

    if (((Width % Stages) != 0) || (Width > MaxWidth)) begin : g_cfg_check
        $error("pipe_adder: Width must be a multiple of Stages and no larger than MaxWidth");
    end

    stage_t           src_s   [Stages];
    stage_t           stage_d [Stages];
    stage_t           stage_q [Stages];
    logic [Chunk-1:0] sl_a    [Stages];
    logic [Chunk-1:0] sl_b    [Stages];
    logic [Chunk-1:0] sl_sum  [Stages];
    logic             sl_cout [Stages];
    logic             advance;
    stage_t           last;
    logic             unused_last;

    always_comb begin
        advance  = !stage_q[Stages-1].valid || out_ready;
        in_ready = advance;
    end

    // Stage k consumes chunk k of the operands carried alongside the transaction.
    always_comb begin
        src_s[0]       = '0;
        src_s[0].valid = in_valid;
        src_s[0].a     = MaxWidth'(a);
        src_s[0].b     = MaxWidth'(b);
        for (int unsigned k = 1; k < Stages; k++) begin
            src_s[k] = stage_q[k-1];
        end
        for (int unsigned k = 0; k < Stages; k++) begin
            sl_a[k] = src_s[k].a[k*Chunk +: Chunk];
            sl_b[k] = src_s[k].b[k*Chunk +: Chunk];
        end
    end

    for (genvar k = 0; k < Stages; k++) begin : g_slice
        add_slice #(.Chunk(Chunk)) u_add_slice (
            .a     (sl_a[k]),
            .b     (sl_b[k]),
            .c_in  (src_s[k].carry),
            .sum   (sl_sum[k]),
            .c_out (sl_cout[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < Stages; k++) begin
            stage_d[k]                        = src_s[k];
            stage_d[k].carry                  = sl_cout[k];
            stage_d[k].psum[k*Chunk +: Chunk] = sl_sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        last      = stage_q[Stages-1];
        out_valid = last.valid;
        c_out     = last.carry;
`ifdef PIPE_ADDER_SAT_EN
        sum       = last.carry ? '1 : last.psum[Width-1:0];
`else
        sum       = last.psum[Width-1:0];
`endif
        // Final-stage operand copies and upper sum bits have no consumer.
        unused_last = ^{last.a, last.b, last.psum};
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder at Width=16, Stages=4 (honours PIPE_ADDER_SAT_EN).
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        out_valid;
    logic        out_ready;

    int          total;
    int          bad;
    logic [16:0] exp_q [$];

    pipe_adder #(.Width(16), .Stages(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model_out(input logic [16:0] raw);
`ifdef PIPE_ADDER_SAT_EN
        if (raw[16]) return 17'h1FFFF;
`endif
        return raw;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic [16:0] raw);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(model_out(raw));
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Every completed output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", 32'(out_valid), 32'd0);
            end else begin
                check("result", 32'({c_out, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [15:0] ov_a   [4] = '{16'hFFFF, 16'h8000, 16'h1234, 16'hFFFF};
    logic [15:0] ov_b   [4] = '{16'h0001, 16'h8000, 16'h4321, 16'hFFFF};
    logic [16:0] ov_raw [4] = '{17'h10000, 17'h10000, 17'h05555, 17'h1FFFE};

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h0000);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Chunk carry and exact latency
        send(16'h00FF, 16'h0001, 17'h00100);
        step();
        step();
        @(negedge clk);
        check("lat_early", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("carry_sum", 32'(sum), 32'h0100);
        check("carry_c_out", 32'(c_out), 32'd0);
        step();

        // Overflow and mixed patterns
        for (int i = 0; i < 4; i++) begin
            send(ov_a[i], ov_b[i], ov_raw[i]);
        end
        drain(20);
        step();

        // Streaming: 8 back-to-back accepts, 8 contiguous results
        for (int i = 0; i < 8; i++) begin
            a        = 16'(32'h1000 * i);
            b        = 16'(i);
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_ready", 32'(in_ready), 32'd1);
            if (i >= 4) check("stream_gap", 32'(out_valid), 32'd1);
            exp_q.push_back(17'(32'h1000 * i + i));
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("stream_gap", 32'(out_valid), 32'd1);
            step();
        end
        @(negedge clk);
        check("stream_end", 32'(out_valid), 32'd0);
        drain(5);
        step();

        // Backpressure
        send(16'h0001, 16'h0002, 17'h00003);
        send(16'h7FFF, 16'h0001, 17'h08000);
        send(16'hF000, 16'h1000, 17'h10000);
        out_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) break;
            step();
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_first", 32'({c_out, sum}), 32'h00003);
        for (int n = 0; n < 3; n++) begin
            step();
            @(negedge clk);
            check("bp_hold_sum", 32'({c_out, sum}), 32'h00003);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        out_ready = 1'b1;
        drain(20);
        step();

        // Mid-operation reset discards in-flight work
        a        = 16'h0011;
        b        = 16'h0022;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        for (int n = 0; n < 8; n++) begin
            step();
            @(negedge clk);
            check("mrst_no_out", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
